// File: rtl/lut_mult_serial.sv
// ---------------------------------------------------------------------------
// lut_mult_serial
//
// Digit-serial multiplier by a run-time reloadable constant A. The odd
// multiples 1A, 3A, ..., 15A live in an 8-entry LUT. Each 4-bit digit d of
// X is written as d = o * 2^k with o odd, so its partial product is one
// LUT read followed by a small left shift. One digit is consumed per clock,
// least significant first.
//
// Loading a new constant rebuilds the LUT in 8 cycles. Entry k is formed by
// adding 2A to entry k-1, so the rebuild needs no multiplier.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   const_load  request to load const_in as the new constant (IDLE only)
//   const_in    new constant value
//   const_busy  high whenever the block is not idle
//   in_valid    x_in is valid
//   in_ready    block can accept x_in this cycle (combinational)
//   x_in        multiplicand
//   out_valid   product is valid (registered)
//   out_ready   downstream accepts product
//   product     x_in * A (registered, held after the handshake)
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting; const_load wins over in_valid
// BUILD  | 8 cycles, writing LUT entry build_cnt
// RUN    | D cycles, accumulating one digit per cycle
// DONE   | product presented, waiting for out_ready
// ---------------------------------------------------------------------------
module lut_mult_serial #(
    parameter int X_WIDTH = 8,
    parameter int A_WIDTH = 8,
    parameter int A_RESET = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       const_load,
    input  logic [A_WIDTH-1:0]         const_in,
    output logic                       const_busy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [X_WIDTH-1:0]         x_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [X_WIDTH+A_WIDTH-1:0] product
);

    localparam int D  = X_WIDTH / 4;
    localparam int LW = A_WIDTH + 4;
    localparam int PW = X_WIDTH + A_WIDTH;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam logic [IW-1:0] LAST_DIGIT = IW'(D - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUILD = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state;
    logic [LW-1:0]      lut [8];
    logic [A_WIDTH-1:0] a_reg;
    logic [A_WIDTH:0]   a2_reg;
    logic [2:0]         build_cnt;
    logic [X_WIDTH-1:0] x_sh;
    logic [IW-1:0]      digit_idx;
    logic [PW-1:0]      acc;

    logic [3:0]         digit;
    logic [1:0]         tz;
    logic [2:0]         lut_idx;
    logic [LW-1:0]      pp;
    logic [PW-1:0]      pp_ext;
    logic [PW-1:0]      acc_next;

    // Odd multiple (2i+1)*A_RESET, the LUT contents right after reset.
    function automatic logic [LW-1:0] reset_entry(input int i);
        reset_entry = LW'((2 * i + 1) * A_RESET);
    endfunction

    assign in_ready   = (state == S_IDLE) && !const_load;
    assign const_busy = (state != S_IDLE);

    // Partial product of the current digit. The shift register always
    // presents the digit being processed in its low nibble.
    always_comb begin
        digit = x_sh[3:0];
        tz    = 2'd3;
        if (digit[0]) begin
            tz = 2'd0;
        end else if (digit[1]) begin
            tz = 2'd1;
        end else if (digit[2]) begin
            tz = 2'd2;
        end
        // (o - 1) / 2 with o = d >> tz and o odd is simply d >> (tz + 1).
        lut_idx = 3'(digit >> ({1'b0, tz} + 3'd1));
        if (digit == 4'd0) begin
            pp = '0;
        end else begin
            // d * A < 16 * 2^A_WIDTH, so the shift cannot overflow LW bits.
            pp = lut[lut_idx] << tz;
        end
        pp_ext   = PW'(pp) << {digit_idx, 2'b00};
        acc_next = acc + pp_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            a_reg     <= A_WIDTH'(A_RESET);
            a2_reg    <= (A_WIDTH + 1)'(2 * A_RESET);
            build_cnt <= '0;
            x_sh      <= '0;
            digit_idx <= '0;
            acc       <= '0;
            product   <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                lut[i] <= reset_entry(i);
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (const_load) begin
                        a_reg     <= const_in;
                        a2_reg    <= {const_in, 1'b0};
                        build_cnt <= '0;
                        state     <= S_BUILD;
                    end else if (in_valid) begin
                        x_sh      <= x_in;
                        acc       <= '0;
                        digit_idx <= '0;
                        state     <= S_RUN;
                    end
                end

                S_BUILD: begin
                    if (build_cnt == 3'd0) begin
                        lut[0] <= LW'(a_reg);
                    end else begin
                        lut[build_cnt] <= lut[build_cnt - 3'd1] + LW'(a2_reg);
                    end
                    build_cnt <= build_cnt + 3'd1;
                    if (build_cnt == 3'd7) begin
                        state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    acc       <= acc_next;
                    x_sh      <= x_sh >> 4;
                    digit_idx <= digit_idx + IW'(1);
                    if (digit_idx == LAST_DIGIT) begin
                        product   <= acc_next;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
